// File: rtl/i2s_rx.sv
// i2s_rx: I2S slave receiver, {right,left} frames on valid/ready; I2S_RX_LJ_EN adds fmt_lj left-justified mode
module i2s_rx #(
  parameter int WIDTH = 16
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               enable,
  input  logic               sclk,
  input  logic               lrck,
  input  logic               sdin,
`ifdef I2S_RX_LJ_EN
  input  logic               fmt_lj,
`endif
  output logic [2*WIDTH-1:0] smp_data,
  output logic               smp_valid,
  input  logic               smp_ready,
  output logic               overrun,
  input  logic               ovr_clr,
  output logic               active
);
  typedef enum logic [1:0] {IDLE, SYNC, LEFT, RIGHT} state_t;
  localparam int CW = $clog2(WIDTH + 2);
  state_t state_q, state_d;
  logic [2:0] sclk_q, sclk_d, lrck_q, lrck_d, sdin_q, sdin_d;
  logic [CW-1:0] bitcnt_q, bitcnt_d, cnt_base, idx;
  logic [WIDTH-1:0] shift_q, shift_d, left_q, left_d;
  logic [2*WIDTH-1:0] smp_data_q, smp_data_d;
  logic smp_valid_q, smp_valid_d, overrun_q, overrun_d, lj_q, lj_d;
  logic sclk_rise, lrck_rise, lrck_fall, lrck_edge, off, cap, commit, load, drop;
  always_comb begin
    sclk_d = {sclk_q[1:0], sclk};
    lrck_d = {lrck_q[1:0], lrck};
    sdin_d = {sdin_q[1:0], sdin};
    sclk_rise = sclk_q[2:1] == 2'b01;
    lrck_rise = lrck_q[2:1] == 2'b01;
    lrck_fall = lrck_q[2:1] == 2'b10;
    lrck_edge = lrck_rise | lrck_fall;
`ifdef I2S_RX_LJ_EN
    lj_d = (state_q == IDLE || state_q == SYNC) ? fmt_lj : lj_q;
`else
    lj_d = 1'b0;
`endif
    // I2S skips the delay bit at bitcnt 0; LJ captures from bitcnt 0
    off = ~lj_q;
    // an lrck edge restarts the half-frame before any same-cycle sclk edge is counted
    cnt_base = lrck_edge ? '0 : bitcnt_q;
    shift_d = lrck_edge ? '0 : shift_q;
    idx = cnt_base - CW'(off);
    cap = sclk_rise && cnt_base >= CW'(off) && idx < CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (cap && idx == CW'(WIDTH - 1 - i)) shift_d[i] = sdin_q[2];
    bitcnt_d = (sclk_rise && cnt_base != CW'(WIDTH + 1)) ? cnt_base + CW'(1) : cnt_base;
    state_d = state_q;
    left_d = left_q;
    commit = 1'b0;
    if (!enable) state_d = IDLE;
    else
      case (state_q)
        IDLE: state_d = SYNC;
        SYNC: state_d = lrck_fall ? LEFT : SYNC;
        LEFT: begin
          state_d = lrck_rise ? RIGHT : LEFT;
          left_d = lrck_rise ? shift_q : left_q;
        end
        RIGHT: begin
          state_d = lrck_fall ? LEFT : RIGHT;
          commit = lrck_fall;
        end
        default: state_d = IDLE;
      endcase
    load = commit && (!smp_valid_q || smp_ready);
    drop = commit && smp_valid_q && !smp_ready;
    smp_data_d = load ? {shift_q, left_q} : smp_data_q;
    smp_valid_d = load | (smp_valid_q & ~smp_ready);
    overrun_d = drop | (overrun_q & ~ovr_clr);
  end
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q <= IDLE;
      sclk_q <= '0;
      lrck_q <= '0;
      sdin_q <= '0;
      bitcnt_q <= '0;
      shift_q <= '0;
      left_q <= '0;
      smp_data_q <= '0;
      smp_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      lj_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sclk_q <= sclk_d;
      lrck_q <= lrck_d;
      sdin_q <= sdin_d;
      bitcnt_q <= bitcnt_d;
      shift_q <= shift_d;
      left_q <= left_d;
      smp_data_q <= smp_data_d;
      smp_valid_q <= smp_valid_d;
      overrun_q <= overrun_d;
      lj_q <= lj_d;
    end
  end
  assign smp_data = smp_data_q;
  assign smp_valid = smp_valid_q;
  assign overrun = overrun_q;
  assign active = state_q == LEFT || state_q == RIGHT;
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed self-checking bench for i2s_rx; set I2S_RX_LJ_EN to also cover left-justified mode
module tb_i2s_rx;
  logic clk, reset, enable, sclk, lrck, sdin, smp_ready, ovr_clr;
  logic [31:0] smp_data;
  logic smp_valid, overrun, active;
`ifdef I2S_RX_LJ_EN
  logic fmt_lj;
`endif
  int checks = 0;
  int errors = 0;
  i2s_rx dut (
    .clkin(clk), .reset(reset), .enable(enable), .sclk(sclk), .lrck(lrck), .sdin(sdin),
`ifdef I2S_RX_LJ_EN
    .fmt_lj(fmt_lj),
`endif
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .overrun(overrun), .ovr_clr(ovr_clr), .active(active)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  // one sclk period of 16 clkin: data changes with the falling sclk; rp pulses smp_ready in the commit cycle
  task automatic slot(input logic b, input bit rp);
    sclk = 0;
    sdin = b;
    if (rp) begin
      repeat (2) @(negedge clk);
      smp_ready = 1;
      @(negedge clk);
      smp_ready = 0;
      repeat (5) @(negedge clk);
    end else repeat (8) @(negedge clk);
    sclk = 1;
    repeat (8) @(negedge clk);
  endtask
  // I2S halves carry a delay slot (driven 1 so a wrongly captured delay bit shows up) before n data bits
  task automatic half(input logic lr, input logic [15:0] w, input int n, input bit lj, input bit rp);
    lrck = lr;
    if (!lj) slot(1'b1, rp);
    for (int i = 0; i < n; i++) slot(w[15-i], rp && lj && i == 0);
  endtask
  task automatic frame(input logic [15:0] l, input logic [15:0] r);
    half(1'b0, l, 16, 1'b0, 1'b0);
    half(1'b1, r, 16, 1'b0, 1'b0);
  endtask
  task automatic do_reset;
    reset = 1; enable = 0; smp_ready = 0; ovr_clr = 0; lrck = 1; sclk = 1; sdin = 0;
`ifdef I2S_RX_LJ_EN
    fmt_lj = 0;
`endif
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask
  task automatic test_reset;
    do_reset;
    checks++; if (smp_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h exp 00000000", smp_data); end
    checks++; if (smp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", smp_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b exp 0", overrun); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b exp 0", active); end
  endtask
  task automatic test_frame;
    do_reset;
    enable = 1;
    frame(16'h1234, 16'hABCD);
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL frame_active: got %b exp 1", active); end
    lrck = 0; sclk = 0; sdin = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (smp_valid !== 1'b0) begin errors++; $display("FAIL lat_early: valid %b exp 0", smp_valid); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (smp_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: valid %b exp 1", smp_valid); end
    checks++; if (smp_data !== 32'hABCD1234) begin errors++; $display("FAIL frame_data: got %h exp abcd1234", smp_data); end
    @(negedge clk);
    repeat (4) @(negedge clk);
    sclk = 1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 16; i++) slot(1'b0, 1'b0);
    checks++; if (smp_valid !== 1'b1 || smp_data !== 32'hABCD1234) begin errors++; $display("FAIL frame_hold: valid %b data %h exp 1 abcd1234", smp_valid, smp_data); end
    smp_ready = 1;
    @(negedge clk);
    smp_ready = 0;
    checks++; if (smp_valid !== 1'b0) begin errors++; $display("FAIL frame_accept: valid %b exp 0", smp_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL frame_overrun: got %b exp 0", overrun); end
  endtask
  task automatic test_enable_mid;
    logic [15:0] r = 16'h3C3C;
    do_reset;
    half(1'b0, 16'h1111, 16, 1'b0, 1'b0);
    lrck = 1;
    slot(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) slot(r[15-i], 1'b0);
    enable = 1;
    for (int i = 8; i < 16; i++) slot(r[15-i], 1'b0);
    frame(16'h2222, 16'h3333);
    checks++; if (smp_valid !== 1'b0) begin errors++; $display("FAIL en_partial: valid %b exp 0", smp_valid); end
    half(1'b0, 16'h0000, 16, 1'b0, 1'b0);
    checks++; if (smp_valid !== 1'b1) begin errors++; $display("FAIL en_valid: valid %b exp 1", smp_valid); end
    checks++; if (smp_data !== 32'h33332222) begin errors++; $display("FAIL en_data: got %h exp 33332222", smp_data); end
  endtask
  task automatic test_overrun;
    do_reset;
    enable = 1;
    frame(16'h1111, 16'h2222);
    frame(16'h3333, 16'h4444);
    frame(16'h5555, 16'h6666);
    half(1'b0, 16'h0000, 16, 1'b0, 1'b0);
    checks++; if (smp_data !== 32'h22221111) begin errors++; $display("FAIL ovr_data: got %h exp 22221111", smp_data); end
    checks++; if (smp_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b exp 1", smp_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b exp 1", overrun); end
    ovr_clr = 1;
    @(negedge clk);
    ovr_clr = 0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b exp 0", overrun); end
    checks++; if (smp_valid !== 1'b1 || smp_data !== 32'h22221111) begin errors++; $display("FAIL ovr_hold: valid %b data %h exp 1 22221111", smp_valid, smp_data); end
  endtask
  task automatic test_ready_same;
    do_reset;
    enable = 1;
    frame(16'h0101, 16'h0202);
    half(1'b0, 16'h0303, 16, 1'b0, 1'b0);
    half(1'b1, 16'h0404, 16, 1'b0, 1'b0);
    checks++; if (smp_valid !== 1'b1 || smp_data !== 32'h02020101) begin errors++; $display("FAIL rs_pre: valid %b data %h exp 1 02020101", smp_valid, smp_data); end
    half(1'b0, 16'h0000, 16, 1'b0, 1'b1);
    checks++; if (smp_valid !== 1'b1) begin errors++; $display("FAIL rs_valid: got %b exp 1", smp_valid); end
    checks++; if (smp_data !== 32'h04040303) begin errors++; $display("FAIL rs_data: got %h exp 04040303", smp_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rs_overrun: got %b exp 0", overrun); end
  endtask
  task automatic test_short;
    do_reset;
    enable = 1;
    smp_ready = 1;
    half(1'b0, 16'hFFFF, 10, 1'b0, 1'b0);
    half(1'b1, 16'h1234, 16, 1'b0, 1'b0);
    half(1'b0, 16'h0001, 16, 1'b0, 1'b0);
    checks++; if (smp_data !== 32'h1234FFC0) begin errors++; $display("FAIL short_left: got %h exp 1234ffc0", smp_data); end
    half(1'b1, 16'hFFFF, 10, 1'b0, 1'b0);
    half(1'b0, 16'h0000, 16, 1'b0, 1'b0);
    checks++; if (smp_data !== 32'hFFC00001) begin errors++; $display("FAIL short_right: got %h exp ffc00001", smp_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL short_overrun: got %b exp 0", overrun); end
    smp_ready = 0;
  endtask
  task automatic test_reset_mid;
    do_reset;
    enable = 1;
    frame(16'h1234, 16'hABCD);
    lrck = 0;
    slot(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) slot(1'b1, 1'b0);
    reset = 1;
    @(negedge clk);
    checks++; if (smp_data !== 32'h0 || smp_valid !== 1'b0) begin errors++; $display("FAIL rmid_out: data %h valid %b exp 00000000 0", smp_data, smp_valid); end
    checks++; if (active !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rmid_state: active %b overrun %b exp 0 0", active, overrun); end
    reset = 0;
    for (int i = 5; i < 16; i++) slot(1'b1, 1'b0);
    half(1'b1, 16'h0000, 16, 1'b0, 1'b0);
    frame(16'h5555, 16'hAAAA);
    half(1'b0, 16'h0000, 16, 1'b0, 1'b0);
    checks++; if (smp_valid !== 1'b1 || smp_data !== 32'hAAAA5555) begin errors++; $display("FAIL rmid_next: valid %b data %h exp 1 aaaa5555", smp_valid, smp_data); end
  endtask
  task automatic test_disable_mid;
    do_reset;
    enable = 1;
    frame(16'h1234, 16'hABCD);
    lrck = 0;
    slot(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) slot(1'b1, 1'b0);
    enable = 0;
    repeat (2) @(negedge clk);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL dis_active: got %b exp 0", active); end
    checks++; if (smp_valid !== 1'b1 || smp_data !== 32'hABCD1234) begin errors++; $display("FAIL dis_keep: valid %b data %h exp 1 abcd1234", smp_valid, smp_data); end
    smp_ready = 1;
    @(negedge clk);
    smp_ready = 0;
    checks++; if (smp_valid !== 1'b0) begin errors++; $display("FAIL dis_accept: got %b exp 0", smp_valid); end
    enable = 1;
    for (int i = 5; i < 16; i++) slot(1'b1, 1'b0);
    half(1'b1, 16'h0000, 16, 1'b0, 1'b0);
    frame(16'h0F0F, 16'hF0F0);
    half(1'b0, 16'h0000, 16, 1'b0, 1'b0);
    checks++; if (smp_valid !== 1'b1 || smp_data !== 32'hF0F00F0F) begin errors++; $display("FAIL dis_next: valid %b data %h exp 1 f0f00f0f", smp_valid, smp_data); end
  endtask
`ifdef I2S_RX_LJ_EN
  task automatic test_lj;
    do_reset;
    fmt_lj = 1;
    enable = 1;
    half(1'b0, 16'h8001, 16, 1'b1, 1'b0);
    half(1'b1, 16'h4002, 16, 1'b1, 1'b0);
    half(1'b0, 16'h0000, 16, 1'b1, 1'b0);
    checks++; if (smp_valid !== 1'b1 || smp_data !== 32'h40028001) begin errors++; $display("FAIL lj_data: valid %b data %h exp 1 40028001", smp_valid, smp_data); end
    fmt_lj = 0;
  endtask
`endif
  initial begin
    test_reset;
    test_frame;
    test_enable_mid;
    test_overrun;
    test_ready_same;
    test_short;
    test_reset_mid;
    test_disable_mid;
`ifdef I2S_RX_LJ_EN
    test_lj;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
